axis_bit_serializer: RTL
========================

# axis_bit_serializer

Transmit-side bit serializer that drains the byte-wide AXI-Stream output of the sync FIFO and emits one bit per symbol strobe to the PSK modulator. Each frame (first byte flagged by `tuser`, last byte flagged by `tlast`) gets a fixed sync word prepended and is sent MSB first. Bytes outside a frame are dropped. A frame that runs dry mid-stream is aborted.

## Interface
- `DATA_WIDTH`, 8, byte width of `s_axis_tdata` and bits serialized per beat.
- `PREAMBLE_LEN`, 16, number of sync-word bits sent before frame data (≥1).
- `PREAMBLE_WORD`, 16'hEB90, sync word, `PREAMBLE_LEN` bits, sent MSB first.
- `IDLE_BIT`, 1'b0, value driven on `tx_bit` when no frame is active.

Ports:
- `s_axis_aclk`  in  1  clock (clk_32M768)
- `s_axis_aresetn`  in  1  reset, asynchronous, active-low
- `s_axis_tdata`  in  DATA_WIDTH  byte from FIFO
- `s_axis_tvalid`  in  1  byte valid
- `s_axis_tready`  out  1  holding register empty
- `s_axis_tlast`  in  1  last byte of frame
- `s_axis_tuser`  in  1  first byte of frame
- `sym_tick`  in  1  one-cycle bit-rate strobe
- `tx_bit`  out  1  serial bit, held between ticks
- `tx_bit_valid`  out  1  high while `tx_bit` is a frame bit (preamble or data)
- `tx_sof`  out  1  one-cycle pulse when the first preamble bit is presented
- `tx_eof`  out  1  one-cycle pulse when the last data bit is presented
- `tx_underrun`  out  1  one-cycle pulse when a frame is aborted because no byte was available
- `tx_drop`  out  1  one-cycle pulse when an out-of-frame byte is discarded

## Operation
Holding register:
- Stores `{tuser, tlast, tdata}` plus `hold_valid`.
- `s_axis_tready = !hold_valid`.
- Handshake sets `hold_valid`; the serializer consuming the byte clears it.
- No write and consume in the same cycle is possible, because `tready` is low while the register is full.

States: IDLE, PREAMBLE, DATA. All state changes occur only in cycles with `sym_tick`=1.

IDLE (`tx_bit`=IDLE_BIT, `tx_bit_valid`=0). On a tick:
- If `hold_valid` and `tuser`=1: latch the byte into the shift register, consume it, present preamble bit [PREAMBLE_LEN-1], pulse `tx_sof`, go to PREAMBLE.
- If `hold_valid` and `tuser`=0: consume and discard the byte, pulse `tx_drop`, stay in IDLE.
- No tick: nothing happens; a waiting byte remains held.

PREAMBLE:
- Each tick presents the next lower preamble bit.
- On the tick after bit 0 is presented, present data MSB and go to DATA.

DATA:
- Each tick presents the next lower data bit, counting DATA_WIDTH bits per byte.
- On the tick after the LSB is presented:
  - If the current byte had `tlast`=1: go to IDLE.
  - Else if `hold_valid`: load and consume the next byte, present its MSB. Its `tuser` is ignored and it is treated as data.
  - Else: go to IDLE and pulse `tx_underrun`. The aborted frame gets no `tx_eof`.
- `tx_eof` pulses in the same cycle the LSB of a `tlast` byte is presented.

Counters:
- Bit counter width is `$clog2(max(PREAMBLE_LEN, DATA_WIDTH))`.
- It is reloaded on each state or byte entry and never wraps past its terminal count.

Reset mid-operation:
- All state, including the holding register, clears immediately and the in-flight frame is lost.
- No `tx_underrun` or `tx_eof` is generated.

## Timing
Reset values:
- `s_axis_tready`=1, `tx_bit`=IDLE_BIT, `tx_bit_valid`=0.
- `tx_sof`, `tx_eof`, `tx_underrun`, `tx_drop` = 0.

Output registers and pulses:
- All outputs except `s_axis_tready` are registered.
- They update on the clock edge that samples `sym_tick`=1 and are valid from the following cycle.
- Pulses last exactly one clock.

Throughput constraints:
- `sym_tick` spacing must be ≥2 clocks, so the holding register can refill between ticks.
- At spacing ≥2 with a non-empty FIFO, frames have no gaps.

Latency:
- Byte handshake at cycle N: the first tick usable for it is at cycle ≥N+1.
- A frame of B bytes occupies exactly PREAMBLE_LEN + B·DATA_WIDTH ticks with `tx_bit_valid`=1.
- `tx_bit_valid` falls on the tick following the last bit.

## Test plan
- **Reset:** hold `s_axis_aresetn`=0 with random inputs -> `s_axis_tready`=1, `tx_bit`=0, `tx_bit_valid`=0, all pulses 0.
- **Single-byte frame:** 0xA5 with tuser=1, tlast=1, tick every 4 clocks -> 24 valid bits 1110101110010000_10100101. `tx_sof` on bit 1, `tx_eof` on bit 24, then `tx_bit_valid`=0.
- **Two-byte frame:** 0x3C(tuser), 0xC3(tlast) from the FIFO, tick every 2 clocks -> 32 contiguous valid bits ending 00111100_11000011, no underrun.
- **Underrun:** 0x55 with tuser=1, tlast=0, second byte withheld -> 24 valid bits. On the 25th tick, `tx_underrun` pulses and `tx_bit_valid`=0. A later 0x12 with tuser=0 produces `tx_drop` and no output.
- **Stray byte:** 0xFF with tuser=0 in IDLE -> `tx_drop` pulses on the next tick, `tx_bit_valid` stays 0, `s_axis_tready` returns to 1.
- **Mid-frame reset:** reset asserted during DATA bit 3 -> outputs go to reset values immediately. A new frame 0x81 after release is serialized cleanly with `tx_sof`.

Source files
------------

// File: rtl/axis_bit_serializer.sv
// Byte-to-bit serializer: drains an AXI-Stream byte source into a one-bit-per-tick
// stream, prepending a sync word to each frame and aborting frames that run dry.
module axis_bit_serializer #(
  parameter int unsigned                 DATA_WIDTH    = 8,
  parameter int unsigned                 PREAMBLE_LEN  = 16,
  parameter logic [PREAMBLE_LEN-1:0]     PREAMBLE_WORD = 16'hEB90,
  parameter logic                        IDLE_BIT      = 1'b0
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  sym_tick,
  output logic                  tx_bit,
  output logic                  tx_bit_valid,
  output logic                  tx_sof,
  output logic                  tx_eof,
  output logic                  tx_underrun,
  output logic                  tx_drop
);

  localparam int unsigned MAX_LEN = (PREAMBLE_LEN > DATA_WIDTH) ? PREAMBLE_LEN : DATA_WIDTH;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA
  } state_t;

  state_t state, state_nxt;

  logic                    hold_valid;
  logic                    hold_user;
  logic                    hold_last;
  logic [DATA_WIDTH-1:0]   hold_data;

  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [PREAMBLE_LEN-1:0] pre_sr, pre_sr_nxt;
  logic [DATA_WIDTH-1:0]   data_sr, data_sr_nxt;
  logic                    last_reg, last_nxt;
  logic                    consume;

  logic bit_nxt, valid_nxt, sof_nxt, eof_nxt, underrun_nxt, drop_nxt;

  assign s_axis_tready = !hold_valid;

  // Holding register: tready is low while full, so load and consume never coincide.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      hold_valid <= 1'b0;
      hold_user  <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
    end else if (consume) begin
      hold_valid <= 1'b0;
    end else if (s_axis_tvalid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_user  <= s_axis_tuser;
      hold_last  <= s_axis_tlast;
      hold_data  <= s_axis_tdata;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      pre_sr       <= '0;
      data_sr      <= '0;
      last_reg     <= 1'b0;
      tx_bit       <= IDLE_BIT;
      tx_bit_valid <= 1'b0;
      tx_sof       <= 1'b0;
      tx_eof       <= 1'b0;
      tx_underrun  <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pre_sr       <= pre_sr_nxt;
      data_sr      <= data_sr_nxt;
      last_reg     <= last_nxt;
      tx_bit       <= bit_nxt;
      tx_bit_valid <= valid_nxt;
      tx_sof       <= sof_nxt;
      tx_eof       <= eof_nxt;
      tx_underrun  <= underrun_nxt;
      tx_drop      <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sym_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (hold_valid && hold_user) state_nxt = ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (cnt == '0) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if ((cnt == '0) && (last_reg || !hold_valid)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // cnt holds the number of bits of the current field still to be presented.
  always_comb begin
    consume      = 1'b0;
    cnt_nxt      = cnt;
    pre_sr_nxt   = pre_sr;
    data_sr_nxt  = data_sr;
    last_nxt     = last_reg;
    bit_nxt      = tx_bit;
    valid_nxt    = tx_bit_valid;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    underrun_nxt = 1'b0;
    drop_nxt     = 1'b0;
    if (sym_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (hold_valid) begin
            consume = 1'b1;
            if (hold_user) begin
              data_sr_nxt = hold_data;
              last_nxt    = hold_last;
              pre_sr_nxt  = PREAMBLE_WORD << 1;
              cnt_nxt     = CNT_W'(PREAMBLE_LEN - 1);
              bit_nxt     = PREAMBLE_WORD[PREAMBLE_LEN-1];
              valid_nxt   = 1'b1;
              sof_nxt     = 1'b1;
            end else begin
              drop_nxt = 1'b1;
            end
          end
        end
        ST_PREAMBLE: begin
          if (cnt != '0) begin
            cnt_nxt    = cnt - CNT_W'(1);
            bit_nxt    = pre_sr[PREAMBLE_LEN-1];
            pre_sr_nxt = pre_sr << 1;
          end else begin
            cnt_nxt     = CNT_W'(DATA_WIDTH - 1);
            bit_nxt     = data_sr[DATA_WIDTH-1];
            data_sr_nxt = data_sr << 1;
            eof_nxt     = (DATA_WIDTH == 1) && last_reg;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt_nxt     = cnt - CNT_W'(1);
            bit_nxt     = data_sr[DATA_WIDTH-1];
            data_sr_nxt = data_sr << 1;
            eof_nxt     = (cnt == CNT_W'(1)) && last_reg;
          end else if (last_reg) begin
            bit_nxt   = IDLE_BIT;
            valid_nxt = 1'b0;
          end else if (hold_valid) begin
            // Continuation byte: its tuser flag is deliberately ignored.
            consume     = 1'b1;
            cnt_nxt     = CNT_W'(DATA_WIDTH - 1);
            bit_nxt     = hold_data[DATA_WIDTH-1];
            data_sr_nxt = hold_data << 1;
            last_nxt    = hold_last;
            eof_nxt     = (DATA_WIDTH == 1) && hold_last;
          end else begin
            bit_nxt      = IDLE_BIT;
            valid_nxt    = 1'b0;
            underrun_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
